// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush producer for the 5-stage core pipeline.
// Drives the PC and IF/ID, ID/EX, EX/MEM and MEM/WB register enables and
// the IF/ID, ID/EX synchronous flushes. It handles load-use bubbles,
// taken-branch flushes, a halt drain sequence and, optionally, data-memory
// wait states.
//
// Optional feature macro: PIPE_MEM_WAIT_EN
//   defined   -> mem_access_ex stalls the whole pipe for MEM_WAIT cycles
//   undefined -> mem_access_ex is ignored, memory accesses take one cycle
//
// Handshake: every en_* is a load-enable for its register on the next rising
// edge; a flush_* clears its register at that same edge. The consumer
// registers never push back, so outputs are purely combinational from the
// current state and inputs.
//
// dbg_state exposes the FSM encoding: 0 RUN, 1 MEMWAIT, 2 DRAIN, 3 HALTED.

module pipe_hazard_ctrl #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ra_id,
  input  logic [2:0] rb_id,
  input  logic       use_ra_id,
  input  logic       use_rb_id,
  input  logic       regwrite_ex,
  input  logic [2:0] regwrite_adr_ex,
  input  logic       load_ex,
  input  logic       mem_access_ex,
  input  logic       branch_taken_ex,
  input  logic       is_halt_ex,
  output logic       pc_en,
  output logic       en_ifid,
  output logic       en_idex,
  output logic       en_exmem,
  output logic       en_memwb,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       halted,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       load_use;
  logic       mem_stall;

  // A MEM_WAIT outside 1..15 cannot be represented by the 4-bit counter.
  if (MEM_WAIT < 1 || MEM_WAIT > 15) begin : g_bad_mem_wait
    $error("pipe_hazard_ctrl: MEM_WAIT must be in 1..15");
  end

`ifdef PIPE_MEM_WAIT_EN
  localparam logic [3:0] WAIT_RELOAD = 4'(MEM_WAIT - 1);

  // Set once an access has paid its wait, so the released cycle lets it move.
  logic served;

  assign mem_stall = mem_access_ex & ~served;
`else
  logic unused_mem_access;

  assign unused_mem_access = mem_access_ex;
  assign mem_stall         = 1'b0;
`endif

  // Register 0 is deliberately compared like any other register.
  assign load_use = regwrite_ex & load_ex &
                    ((use_ra_id & (ra_id == regwrite_adr_ex)) |
                     (use_rb_id & (rb_id == regwrite_adr_ex)));

  assign dbg_state = state;

  // Enable/flush decode: priority halt > memory wait > branch > load-use.
  always_comb begin
    pc_en      = 1'b0;
    en_ifid    = 1'b0;
    en_idex    = 1'b0;
    en_exmem   = 1'b0;
    en_memwb   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    halted     = 1'b0;
    if (reset) begin
      case (state)
        RUN: begin
          pc_en    = 1'b1;
          en_ifid  = 1'b1;
          en_idex  = 1'b1;
          en_exmem = 1'b1;
          en_memwb = 1'b1;
          if (is_halt_ex) begin
            pc_en      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
          end else if (mem_stall) begin
            pc_en    = 1'b0;
            en_ifid  = 1'b0;
            en_idex  = 1'b0;
            en_exmem = 1'b0;
            en_memwb = 1'b0;
          end else if (branch_taken_ex) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
          end
        end
        MEMWAIT: begin
          // Whole pipe frozen; defaults already hold every enable low.
        end
        DRAIN: begin
          en_idex    = 1'b1;
          en_exmem   = 1'b1;
          en_memwb   = 1'b1;
          flush_idex = 1'b1;
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // FSM, shared wait/drain counter and served flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 4'd0;
`ifdef PIPE_MEM_WAIT_EN
      served <= 1'b0;
`endif
    end else begin
`ifdef PIPE_MEM_WAIT_EN
      if (en_idex) served <= 1'b0;
`endif
      case (state)
        RUN: begin
          if (is_halt_ex) begin
            state <= DRAIN;
            cnt   <= 4'd1;
          end
`ifdef PIPE_MEM_WAIT_EN
          else if (mem_stall) begin
            if (MEM_WAIT == 1) begin
              served <= 1'b1;
            end else begin
              cnt   <= WAIT_RELOAD;
              state <= MEMWAIT;
            end
          end
`endif
        end
        MEMWAIT: begin
`ifdef PIPE_MEM_WAIT_EN
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            served <= 1'b1;
            state  <= RUN;
          end
`else
          state <= RUN;
`endif
        end
        DRAIN: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else state <= HALTED;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Outputs are packed as
// {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, halted}.
// With PIPE_MEM_WAIT_EN defined the DUT runs with MEM_WAIT = 3.

module tb_pipe_hazard_ctrl;

  localparam logic [7:0] V_RST    = 8'h00;
  localparam logic [7:0] V_RUN    = 8'hF8;
  localparam logic [7:0] V_BUBBLE = 8'h3A; // pc/ifid held, idex flushed
  localparam logic [7:0] V_BRANCH = 8'hFE;
  localparam logic [7:0] V_FROZEN = 8'h00;
  localparam logic [7:0] V_HALTED = 8'h01;

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_MEMWAIT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_HALTED  = 2'd3;

  logic       clk;
  logic       reset;
  logic [2:0] ra_id, rb_id, regwrite_adr_ex;
  logic       use_ra_id, use_rb_id, regwrite_ex, load_ex;
  logic       mem_access_ex, branch_taken_ex, is_halt_ex;
  logic       pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic       flush_ifid, flush_idex, halted;
  logic [1:0] dbg_state;
  logic [7:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  pipe_hazard_ctrl #(.MEM_WAIT(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .ra_id           (ra_id),
    .rb_id           (rb_id),
    .use_ra_id       (use_ra_id),
    .use_rb_id       (use_rb_id),
    .regwrite_ex     (regwrite_ex),
    .regwrite_adr_ex (regwrite_adr_ex),
    .load_ex         (load_ex),
    .mem_access_ex   (mem_access_ex),
    .branch_taken_ex (branch_taken_ex),
    .is_halt_ex      (is_halt_ex),
    .pc_en           (pc_en),
    .en_ifid         (en_ifid),
    .en_idex         (en_idex),
    .en_exmem        (en_exmem),
    .en_memwb        (en_memwb),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .halted          (halted),
    .dbg_state       (dbg_state)
  );

  assign obs = {pc_en, en_ifid, en_idex, en_exmem, en_memwb,
                flush_ifid, flush_idex, halted};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got,
                          input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Driver tasks
  task automatic set_idle();
    ra_id = 3'd0; rb_id = 3'd0; use_ra_id = 1'b0; use_rb_id = 1'b0;
    regwrite_ex = 1'b0; regwrite_adr_ex = 3'd0; load_ex = 1'b0;
    mem_access_ex = 1'b0; branch_taken_ex = 1'b0; is_halt_ex = 1'b0;
  endtask

  task automatic set_load(input logic [2:0] dst);
    regwrite_ex = 1'b1; load_ex = 1'b1; regwrite_adr_ex = dst;
  endtask

  // Checks the current cycle against the scoreboard, then moves one edge on.
  task automatic step(input string tag, input logic [7:0] want,
                      input logic [1:0] want_state);
    logic [7:0] e;
    exp_q.push_back(want);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, obs, e);
    check_eq({tag, "_state"}, {6'd0, dbg_state}, {6'd0, want_state});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    step("reset", V_RST, S_RUN);
    reset = 1'b1;
    step("run_default", V_RUN, S_RUN);

    // Load-use on ra, one bubble, then the load has moved on.
    set_load(3'd3); ra_id = 3'd3; use_ra_id = 1'b1;
    step("lu_ra", V_BUBBLE, S_RUN);
    set_idle();
    step("lu_after", V_RUN, S_RUN);
    set_load(3'd3); ra_id = 3'd3; use_ra_id = 1'b0;
    step("lu_ra_unused", V_RUN, S_RUN);
    set_idle(); set_load(3'd5); rb_id = 3'd5; use_rb_id = 1'b1; ra_id = 3'd5;
    step("lu_rb", V_BUBBLE, S_RUN);
    set_idle(); set_load(3'd0); ra_id = 3'd0; use_ra_id = 1'b1;
    step("lu_r0", V_BUBBLE, S_RUN);
    set_idle(); set_load(3'd2); ra_id = 3'd3; use_ra_id = 1'b1;
    step("lu_nomatch", V_RUN, S_RUN);
    set_idle(); regwrite_ex = 1'b1; regwrite_adr_ex = 3'd3;
    ra_id = 3'd3; use_ra_id = 1'b1;
    step("alu_no_lu", V_RUN, S_RUN);

    // Branch alone, and branch beating a load-use.
    set_idle(); branch_taken_ex = 1'b1;
    step("branch", V_BRANCH, S_RUN);
    set_load(3'd4); ra_id = 3'd4; use_ra_id = 1'b1;
    step("branch_lu", V_BRANCH, S_RUN);
    set_idle();
    step("branch_after", V_RUN, S_RUN);

`ifdef PIPE_MEM_WAIT_EN
    // MEM_WAIT = 3: three frozen cycles, then the access advances.
    mem_access_ex = 1'b1;
    step("mw_1", V_FROZEN, S_RUN);
    step("mw_2", V_FROZEN, S_MEMWAIT);
    step("mw_3", V_FROZEN, S_MEMWAIT);
    step("mw_release", V_RUN, S_RUN);
    set_idle();
    step("mw_after", V_RUN, S_RUN);
    // Branch on the frozen instruction acts in the release cycle.
    mem_access_ex = 1'b1; branch_taken_ex = 1'b1;
    step("mwb_1", V_FROZEN, S_RUN);
    step("mwb_2", V_FROZEN, S_MEMWAIT);
    step("mwb_3", V_FROZEN, S_MEMWAIT);
    step("mwb_release", V_BRANCH, S_RUN);
    // Back-to-back access: served cleared, so a fresh wait starts.
    branch_taken_ex = 1'b0;
    step("mw_b2b", V_FROZEN, S_RUN);
    step("mw_b2b_2", V_FROZEN, S_MEMWAIT);
    // Asynchronous reset on stall cycle 2.
    reset = 1'b0;
    #1;
    check_eq("mw_async_rst", obs, V_RST);
    check_eq("mw_async_rst_state", {6'd0, dbg_state}, {6'd0, S_RUN});
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("mwr_1", V_FROZEN, S_RUN);
    step("mwr_2", V_FROZEN, S_MEMWAIT);
    step("mwr_3", V_FROZEN, S_MEMWAIT);
    step("mwr_release", V_RUN, S_RUN);
    set_idle();
`else
    // Memory access costs nothing without the wait feature.
    mem_access_ex = 1'b1;
    step("mem_nostall_1", V_RUN, S_RUN);
    step("mem_nostall_2", V_RUN, S_RUN);
    set_idle();
`endif

    // Halt together with a memory access: halt wins, then drain and stop.
    is_halt_ex = 1'b1; mem_access_ex = 1'b1;
    step("halt_detect", V_BUBBLE, S_RUN);
    set_idle();
    step("drain_1", V_BUBBLE, S_DRAIN);
    step("drain_2", V_BUBBLE, S_DRAIN);
    step("halted_1", V_HALTED, S_HALTED);
    branch_taken_ex = 1'b1; mem_access_ex = 1'b1; is_halt_ex = 1'b1;
    set_load(3'd1); ra_id = 3'd1; use_ra_id = 1'b1;
    step("halted_2", V_HALTED, S_HALTED);
    step("halted_3", V_HALTED, S_HALTED);
    set_idle();

    // Reset out of HALTED is immediate.
    reset = 1'b0;
    #1;
    check_eq("halt_async_rst", obs, V_RST);
    check_eq("halt_async_rst_state", {6'd0, dbg_state}, {6'd0, S_RUN});
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("post_reset", V_RUN, S_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
